// File: rtl/gray_pkg.sv
// Shared types and constants for the Gray-code receive checker.
package gray_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam int unsigned ERR_W = 8;

  // Saturating increment: holds at all-ones instead of wrapping to zero.
  function automatic logic [ERR_W-1:0] err_inc(input logic [ERR_W-1:0] cnt);
    return (cnt == '1) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary decoder, usable by any Gray-domain block.
module gray2bin #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign o_bin[i] = ^i_gray[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_rx_checker.sv
// Synchronizes a Gray count from another domain, decodes it, and tracks
// lock on a +1 stepping sequence, flagging illegal steps and wrap-arounds.
module gray_rx_checker
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_STEPS  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] bin_out,
  output logic             locked,
  output logic             step_err,
  output logic             wrap,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned LC_W = $clog2(LOCK_STEPS + 1);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_prev;
  logic [LC_W-1:0]  r_lock_cnt;
  logic [ERR_W-1:0] r_err_cnt;
  logic             r_locked;
  logic             r_step_err;
  logic             r_wrap;
  state_t           r_state;

  logic [WIDTH-1:0] w_cur;
  logic [WIDTH-1:0] w_delta;
  logic             w_good;
  logic             w_bad;
  logic             w_wrap_step;
  logic [LC_W-1:0]  w_lc_next;

  // Multi-flop synchronizer; only Gray (single-bit-change) values cross here.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= gray_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  gray2bin #(.WIDTH(WIDTH)) u_dec (
    .i_gray (r_sync[SYNC_STAGES-1]),
    .o_bin  (w_cur)
  );

  assign w_delta     = w_cur - r_prev;
  assign w_good      = (w_delta == WIDTH'(1));
  assign w_bad       = (w_delta != '0) && !w_good;
  assign w_wrap_step = w_good && (r_prev == '1) && (w_cur == '0);
  assign w_lc_next   = r_lock_cnt + LC_W'(1);

  // Decode register, step history and lock FSM with registered flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin      <= '0;
      r_prev     <= '0;
      r_lock_cnt <= '0;
      r_err_cnt  <= '0;
      r_locked   <= 1'b0;
      r_step_err <= 1'b0;
      r_wrap     <= 1'b0;
      r_state    <= IDLE;
    end else begin
      r_bin      <= w_cur;
      r_prev     <= w_cur;
      r_step_err <= 1'b0;
      r_wrap     <= 1'b0;
      case (r_state)
        IDLE: begin
          r_lock_cnt <= '0;
          r_locked   <= 1'b0;
          r_state    <= ACQUIRE;
        end
        ACQUIRE: begin
          if (w_good) begin
            r_wrap     <= w_wrap_step;
            r_lock_cnt <= w_lc_next;
            if (w_lc_next == LC_W'(LOCK_STEPS)) begin
              r_state  <= LOCKED;
              r_locked <= 1'b1;
            end
          end else if (w_bad) begin
            r_lock_cnt <= '0;
          end
        end
        LOCKED: begin
          if (w_good) begin
            r_wrap <= w_wrap_step;
          end else if (w_bad) begin
            r_step_err <= 1'b1;
            r_err_cnt  <= err_inc(r_err_cnt);
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
            r_state    <= ACQUIRE;
          end
        end
        default: begin
          r_locked <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign bin_out   = r_bin;
  assign locked    = r_locked;
  assign step_err  = r_step_err;
  assign wrap      = r_wrap;
  assign err_count = r_err_cnt;

endmodule
